hazard_ctrl: RTL and testbench

Pipeline hazard and sequencing controller for the 5-stage core. It drives the stall and flush inputs of every pipeline register, including the `clr` of the decode-to-execute control register. It also generates the execute-stage forwarding selects and holds the pipeline while data memory is busy. It contains a memory-wait FSM with timeout, plus stall and flush event counters for debug.

---
 rtl/pipe_pkg.sv | 19 +
 rtl/fwd_sel.sv | 23 ++
 rtl/hazard_ctrl.sv | 153 +++++++++++++++
 tb/tb_hazard_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared encodings for the hazard controller
package pipe_pkg;

  // Forwarding select encodings for the execute-stage operand muxes
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  // ResultSrcE value that marks a load in execute
  localparam logic [1:0] RESULT_LOAD = 2'b01;

  // Memory-wait FSM states
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FAULT    = 2'd2
  } mem_state_t;

endpackage

// File: rtl/fwd_sel.sv
// rtl/fwd_sel.sv - per-operand forwarding comparator
module fwd_sel
  import pipe_pkg::*;
(
  input  logic [4:0] rs,
  input  logic [4:0] rd_m,
  input  logic       reg_write_m,
  input  logic [4:0] rd_w,
  input  logic       reg_write_w,
  output logic [1:0] sel
);

  // M stage wins over W; x0 is never forwarded
  always_comb begin
    sel = FWD_RF;
    if (reg_write_m && (rd_m != 5'd0) && (rd_m == rs)) begin
      sel = FWD_MEM;
    end else if (reg_write_w && (rd_w != 5'd0) && (rd_w == rs)) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard, forwarding and memory-wait controller
module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic [4:0]       RdM,
  input  logic [4:0]       RdW,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic [1:0]       ResultSrcE,
  input  logic             PCSrcE,
  input  logic             MemReqM,
  input  logic             dmem_ready,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic             mem_fault,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  mem_state_t        state, state_next;
  logic [WAIT_W-1:0] wait_cnt, wait_next;
  logic              freeze;
  logic              load_use;

  fwd_sel u_fwd_a (
    .rs          (Rs1E),
    .rd_m        (RdM),
    .reg_write_m (RegWriteM),
    .rd_w        (RdW),
    .reg_write_w (RegWriteW),
    .sel         (ForwardAE)
  );

  fwd_sel u_fwd_b (
    .rs          (Rs2E),
    .rd_m        (RdM),
    .reg_write_m (RegWriteM),
    .rd_w        (RdW),
    .reg_write_w (RegWriteW),
    .sel         (ForwardBE)
  );

  assign load_use = (ResultSrcE == RESULT_LOAD) && (RdE != 5'd0) &&
                    ((RdE == Rs1D) || (RdE == Rs2D));

  // Memory-wait FSM: wait_cnt counts frozen cycles including the entry cycle
  always_comb begin
    state_next = state;
    wait_next  = wait_cnt;
    freeze     = 1'b0;
    case (state)
      RUN: begin
        if (MemReqM && !dmem_ready) begin
          freeze     = 1'b1;
          state_next = MEM_WAIT;
          wait_next  = WAIT_W'(1);
        end
      end
      MEM_WAIT: begin
        if (dmem_ready) begin
          state_next = RUN;
          wait_next  = '0;
        end else begin
          freeze    = 1'b1;
          wait_next = wait_cnt + WAIT_W'(1);
          if (wait_cnt == WAIT_W'(TIMEOUT - 1)) begin
            state_next = FAULT;
          end
        end
      end
      FAULT: begin
        freeze = 1'b1;
      end
      default: begin
        state_next = RUN;
        wait_next  = '0;
      end
    endcase
  end

  // Stall/flush steering: reset forces idle, freeze dominates, branch beats load-use
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushW = 1'b0;
    if (!reset) begin
      if (freeze) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
        FlushW = 1'b1;
      end else if (PCSrcE) begin
        FlushD = 1'b1;
        FlushE = 1'b1;
      end else if (load_use) begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
      end
    end
  end

  // State register, wait counter and sticky fault flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= RUN;
      wait_cnt  <= '0;
      mem_fault <= 1'b0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_next;
      if (state_next == FAULT) begin
        mem_fault <= 1'b1;
      end
    end
  end

  // Debug event counters, free-running with wraparound
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      stall_cnt <= stall_cnt + CNT_W'(StallF);
      flush_cnt <= flush_cnt + CNT_W'(PCSrcE && !freeze);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - self-checking bench for hazard_ctrl
module tb_hazard_ctrl;

  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [4:0]       Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic             RegWriteM, RegWriteW;
  logic [1:0]       ResultSrcE;
  logic             PCSrcE, MemReqM, dmem_ready;
  logic [1:0]       ForwardAE, ForwardBE;
  logic             StallF, StallD, StallE, StallM;
  logic             FlushD, FlushE, FlushW;
  logic             mem_fault;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int errors = 0;
  int checks = 0;

  hazard_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .Rs1D       (Rs1D),
    .Rs2D       (Rs2D),
    .Rs1E       (Rs1E),
    .Rs2E       (Rs2E),
    .RdE        (RdE),
    .RdM        (RdM),
    .RdW        (RdW),
    .RegWriteM  (RegWriteM),
    .RegWriteW  (RegWriteW),
    .ResultSrcE (ResultSrcE),
    .PCSrcE     (PCSrcE),
    .MemReqM    (MemReqM),
    .dmem_ready (dmem_ready),
    .ForwardAE  (ForwardAE),
    .ForwardBE  (ForwardBE),
    .StallF     (StallF),
    .StallD     (StallD),
    .StallE     (StallE),
    .StallM     (StallM),
    .FlushD     (FlushD),
    .FlushE     (FlushE),
    .FlushW     (FlushW),
    .mem_fault  (mem_fault),
    .stall_cnt  (stall_cnt),
    .flush_cnt  (flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] fwd_model(input logic [4:0] rs);
    if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
    if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  // Model: an access is outstanding until ready; frozen cycles are counted
  bit pend = 0;
  bit faulted = 0;
  int waited = 0;
  int stall_m = 0;
  int flush_m = 0;

  always @(negedge clk) begin
    bit frz, lu, st, fd, fe, fw;
    lu = (ResultSrcE == 2'b01) && (RdE != 0) && (RdE == Rs1D || RdE == Rs2D);
    frz = faulted || ((pend || MemReqM) && !dmem_ready);
    if (reset) begin
      frz = 0; lu = 0; pend = 0; faulted = 0; waited = 0; stall_m = 0; flush_m = 0;
    end
    st = frz || (!reset && !PCSrcE && lu);
    fd = !reset && !frz && PCSrcE;
    fe = !reset && !frz && (PCSrcE || lu);
    fw = frz;
    chk("m_fwd_a", ForwardAE, fwd_model(Rs1E));
    chk("m_fwd_b", ForwardBE, fwd_model(Rs2E));
    chk("m_stall_f", StallF, st);
    chk("m_stall_d", StallD, st);
    chk("m_stall_e", StallE, frz);
    chk("m_stall_m", StallM, frz);
    chk("m_flush_d", FlushD, fd);
    chk("m_flush_e", FlushE, fe);
    chk("m_flush_w", FlushW, fw);
    chk("m_fault", mem_fault, faulted);
    chk("m_stall_cnt", stall_cnt, stall_m % (1 << CNT_W));
    chk("m_flush_cnt", flush_cnt, flush_m % (1 << CNT_W));
    if (!reset) begin
      if (st) stall_m++;
      if (fd) flush_m++;
      if (!faulted) begin
        if (frz) begin
          pend = 1;
          waited++;
          if (waited == TIMEOUT) faulted = 1;
        end else begin
          pend = 0;
          waited = 0;
        end
      end
    end
  end

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1;
    Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
    RegWriteM = 0; RegWriteW = 0; ResultSrcE = 0; PCSrcE = 0; MemReqM = 0; dmem_ready = 0;
    cyc; cyc;
    chk("rst_stall_f", StallF, 0);
    chk("rst_flush_w", FlushW, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_fault", mem_fault, 0);
    reset = 0;

    // forwarding priority
    Rs1E = 5; RdM = 5; RdW = 5; RegWriteM = 1; RegWriteW = 1;
    #1 chk("fwd_mem", ForwardAE, 2'b10);
    RdM = 0;
    #1 chk("fwd_wb", ForwardAE, 2'b01);
    Rs1E = 0;
    #1 chk("fwd_x0", ForwardAE, 2'b00);
    Rs2E = 3; RdW = 3;
    #1 chk("fwd_b_wb", ForwardBE, 2'b01);
    cyc;
    Rs1E = 0; Rs2E = 0; RdM = 0; RdW = 0; RegWriteM = 0; RegWriteW = 0;

    // load-use, then load-use overridden by a branch
    ResultSrcE = 2'b01; RdE = 7; Rs2D = 7;
    #1 chk("lu_stall_f", StallF, 1);
    chk("lu_flush_e", FlushE, 1);
    chk("lu_stall_e", StallE, 0);
    cyc;
    chk("lu_stall_cnt", stall_cnt, 1);
    PCSrcE = 1;
    #1 chk("br_flush_d", FlushD, 1);
    chk("br_flush_e", FlushE, 1);
    chk("br_stall_f", StallF, 0);
    cyc;
    ResultSrcE = 0; RdE = 0; Rs2D = 0;
    chk("br_flush_cnt", flush_cnt, 1);

    // memory wait of 3 cycles with a branch held in E
    MemReqM = 1; dmem_ready = 0; PCSrcE = 1;
    #1 chk("mw_stall_m", StallM, 1);
    chk("mw_flush_w", FlushW, 1);
    chk("mw_flush_d", FlushD, 0);
    cyc; cyc; cyc;
    dmem_ready = 1;
    #1 chk("mw_exit_stall", StallF, 0);
    chk("mw_exit_flush_d", FlushD, 1);
    chk("mw_stall_cnt", stall_cnt, 4);
    cyc;
    chk("mw_flush_cnt", flush_cnt, 2);
    PCSrcE = 0; dmem_ready = 0;
    #1 chk("b2b_stall", StallF, 1);
    cyc;
    dmem_ready = 1;
    #1 chk("b2b_exit", StallF, 0);
    chk("b2b_stall_cnt", stall_cnt, 5);
    cyc;
    chk("same_cycle_ready", StallF, 0);
    cyc;

    // timeout into FAULT, then asynchronous reset
    MemReqM = 1; dmem_ready = 0;
    repeat (15) cyc;
    chk("to_not_yet", mem_fault, 0);
    cyc;
    chk("to_fault", mem_fault, 1);
    MemReqM = 0; dmem_ready = 1;
    #1 chk("to_hold_stall", StallF, 1);
    chk("to_hold_flush_w", FlushW, 1);
    cyc; cyc;
    #1 reset = 1;
    #1 chk("ar_fault", mem_fault, 0);
    chk("ar_stall_f", StallF, 0);
    chk("ar_flush_w", FlushW, 0);
    chk("ar_stall_cnt", stall_cnt, 0);
    cyc;
    reset = 0;
    cyc;
    chk("ar_run", StallF, 0);

    // counter wrap: 17 stall cycles on a 4-bit counter
    ResultSrcE = 2'b01; RdE = 7; Rs1D = 7;
    repeat (17) cyc;
    ResultSrcE = 0; RdE = 0; Rs1D = 0;
    chk("wrap_stall_cnt", stall_cnt, 1);
    cyc; cyc;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
